conv_frame_loader: RTL and testbench

Front-end writer for the convolution integration stage. Accepts a 16-bit pixel stream with a valid/ready handshake and packs it into the flat row-major image bus that the convolution stack consumes. When a full frame is packed, it releases the stack's reset and times the fixed compute window. It then flags the result as ready and holds everything stable until the consumer acknowledges.

---
 rtl/conv_frame_loader_if.sv | 12 +
 rtl/conv_frame_loader.sv | 98 +++++++++
 tb/tb_conv_frame_loader.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/conv_frame_loader_if.sv
// Pixel stream handshake between a word source and the convolution frame loader.
interface conv_frame_loader_if #(
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  s_ready;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/conv_frame_loader.sv
// Packs a pixel stream into a flat row-major frame, then releases the convolution
// stack's reset for a fixed compute window and holds the result until acknowledged.
module conv_frame_loader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IMG_W      = 32,
  parameter int unsigned IMG_H      = 32,
  parameter int unsigned RUN_CYCLES = 107338
) (
  input  logic                              clk,
  input  logic                              reset,
  conv_frame_loader_if.slave                s,
  output logic [IMG_W*IMG_H*DATA_WIDTH-1:0] frame_out,
  output logic                              conv_reset,
  output logic                              result_valid,
  input  logic                              result_ack,
  output logic                              busy,
  output logic                              err_len
);

  localparam int unsigned N    = IMG_W * IMG_H;
  localparam int unsigned FW   = N * DATA_WIDTH;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW = $clog2(RUN_CYCLES + 1);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      frame_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: state_d = StLoad;
      StLoad: begin
        if (s.s_valid) begin
          frame_d[int'(idx_q) * DATA_WIDTH +: DATA_WIDTH] = s.s_data;
          if (idx_q == LastIdx) begin
            // A full frame always runs; a missing s_last is only flagged.
            idx_d   = '0;
            state_d = StRun;
            err_d   = ~s.s_last;
          end else if (s.s_last) begin
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StRun: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (result_ack) state_d = StLoad;
      end
      default: state_d = StIdle;
    endcase
  end

  assign s.s_ready    = (state_q == StLoad);
  assign conv_reset   = (state_q == StIdle) || (state_q == StLoad);
  assign busy         = (state_q == StRun) || (state_q == StDone);
  assign result_valid = (state_q == StDone);
  assign err_len      = err_q;
  assign frame_out    = frame_q;

endmodule

// File: tb/tb_conv_frame_loader.sv
// Directed sequence with random pixel data for conv_frame_loader (4x4 frame, 10-cycle run).
module tb_conv_frame_loader;
  localparam int unsigned DW = 16;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned N  = W * H;
  localparam int unsigned RC = 10;
  localparam int unsigned FW = N * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          result_ack = 1'b0;
  logic [FW-1:0] frame_out;
  logic          conv_reset, result_valid, busy, err_len;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] mem [N];

  conv_frame_loader_if #(.DATA_WIDTH(DW)) bus ();

  conv_frame_loader #(
    .DATA_WIDTH(DW),
    .IMG_W     (W),
    .IMG_H     (H),
    .RUN_CYCLES(RC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s           (bus),
    .frame_out   (frame_out),
    .conv_reset  (conv_reset),
    .result_valid(result_valid),
    .result_ack  (result_ack),
    .busy        (busy),
    .err_len     (err_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [FW-1:0] model_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < int'(N); k++) f[k*DW +: DW] = mem[k];
    return f;
  endfunction

  task automatic push(input logic [DW-1:0] d, input logic last);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_data  = DW'($urandom);
    bus.s_last  = 1'($urandom);
  endtask

  // Sends words 0..nwords-1 with s_last on last_pos; stops early on a short frame.
  task automatic send_frame(input int nwords, input int last_pos, input bit gaps);
    logic [DW-1:0] d;
    for (int k = 0; k < nwords; k++) begin
      d      = DW'($urandom);
      mem[k] = d;
      push(d, k == last_pos);
      if (k == int'(N) - 1) begin
        check("run_conv_reset", FW'(conv_reset), FW'(0));
        check("run_s_ready", FW'(bus.s_ready), FW'(0));
        check("run_busy", FW'(busy), FW'(1));
        check("full_err_len", FW'(err_len), FW'(last_pos != k));
      end else begin
        check("load_s_ready", FW'(bus.s_ready), FW'(1));
        check("load_conv_reset", FW'(conv_reset), FW'(1));
        check("load_err_len", FW'(err_len), FW'(k == last_pos));
        if (k == last_pos) begin
          @(negedge clk);
          check("err_len_pulse_end", FW'(err_len), FW'(0));
          return;
        end
        if (gaps) @(negedge clk);
      end
    end
  endtask

  // Called at a negedge inside RUN, exp_cycles negedges before result_valid must appear.
  task automatic wait_done(input int exp_cycles);
    int cyc = 0;
    while (result_valid !== 1'b1 && cyc < exp_cycles + 20) begin
      if (conv_reset !== 1'b0) check("conv_reset_low_in_run", FW'(conv_reset), FW'(0));
      cyc++;
      @(negedge clk);
    end
    check("run_length", FW'(cyc), FW'(exp_cycles));
    check("done_result_valid", FW'(result_valid), FW'(1));
    check("done_conv_reset", FW'(conv_reset), FW'(0));
    check("done_busy", FW'(busy), FW'(1));
    check("done_frame", frame_out, model_frame());
  endtask

  task automatic ack();
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    check("ack_result_valid", FW'(result_valid), FW'(0));
    check("ack_conv_reset", FW'(conv_reset), FW'(1));
    check("ack_s_ready", FW'(bus.s_ready), FW'(1));
    check("ack_busy", FW'(busy), FW'(0));
  endtask

  initial begin
    logic [FW-1:0] snap;
    bit            stable;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;

    // Reset values, then IDLE -> LOAD on the first edge.
    @(negedge clk);
    check("rst_s_ready", FW'(bus.s_ready), FW'(0));
    check("rst_conv_reset", FW'(conv_reset), FW'(1));
    check("rst_result_valid", FW'(result_valid), FW'(0));
    check("rst_busy", FW'(busy), FW'(0));
    check("rst_err_len", FW'(err_len), FW'(0));
    check("rst_frame", frame_out, FW'(0));
    reset = 1'b0;
    @(negedge clk);
    check("idle_to_load_s_ready", FW'(bus.s_ready), FW'(1));

    // Back-to-back frame.
    send_frame(N, N - 1, 1'b0);
    check("frame_word0", FW'(frame_out[DW-1:0]), FW'(mem[0]));
    check("frame_word15", FW'(frame_out[FW-1 -: DW]), FW'(mem[N-1]));
    wait_done(RC);
    ack();

    // Gapped frame; result held while ack stays low.
    send_frame(N, N - 1, 1'b1);
    wait_done(RC);
    snap   = frame_out;
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (result_valid !== 1'b1 || frame_out !== snap) stable = 1'b0;
    end
    check("done_hold_stable", FW'(stable), FW'(1));
    ack();

    // Early s_last drops the frame; the next full frame starts from word 0.
    send_frame(6, 5, 1'b0);
    check("drop_stays_load", FW'(bus.s_ready), FW'(1));
    send_frame(N, N - 1, 1'b0);
    wait_done(RC);
    ack();

    // Missing s_last still runs; s_valid during RUN is not taken.
    send_frame(N, -1, 1'b0);
    snap        = frame_out;
    bus.s_valid = 1'b1;
    bus.s_data  = DW'($urandom);
    bus.s_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("run_no_ready", FW'(bus.s_ready), FW'(0));
    end
    check("run_frame_frozen", frame_out, snap);
    check("run_no_err", FW'(err_len), FW'(0));
    bus.s_valid = 1'b0;
    wait_done(RC - 3);
    ack();

    // Asynchronous reset in the 4th RUN cycle.
    send_frame(N, N - 1, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_conv_reset", FW'(conv_reset), FW'(1));
    check("arst_busy", FW'(busy), FW'(0));
    check("arst_result_valid", FW'(result_valid), FW'(0));
    check("arst_s_ready", FW'(bus.s_ready), FW'(0));
    check("arst_frame", frame_out, FW'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("arst_reload_s_ready", FW'(bus.s_ready), FW'(1));
    send_frame(N, N - 1, 1'b0);
    wait_done(RC);
    ack();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
